// File: rtl/branch_target_buffer.sv
// 2-way set-associative fetch-side BTB: per-slot lookup, grant bus, train/invalidate.
// Optional same-cycle forwarding of training traffic: define BTB_BYPASS_EN.
`ifndef N
`define N 3
`endif

module branch_target_buffer #(
    parameter int N        = `N,
    parameter int BTB_SETS = 16,
    parameter int TAG_BITS = 8,
    parameter int ADDR     = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N-1:0][ADDR-1:0]   PCs_in,
    input  logic [N-1:0]             slots_valid,
    output logic [N-1:0]             btb_hits,
    output logic [N-1:0][ADDR-1:0]   btb_targets,
    output logic [N-1:0][N-1:0]      branch_gnt_bus,
    output logic                     no_branches_fetched,
    input  logic                     upd_valid,
    input  logic [ADDR-1:0]          upd_pc,
    input  logic [ADDR-1:0]          upd_target,
    input  logic                     inval_valid,
    input  logic [ADDR-1:0]          inval_pc
);

    localparam int IDX_BITS = $clog2(BTB_SETS);

    typedef logic [IDX_BITS-1:0] idx_t;
    typedef logic [TAG_BITS-1:0] tag_t;

    function automatic idx_t pc_idx(input logic [ADDR-1:0] pc);
        return pc[2 +: IDX_BITS];
    endfunction

    function automatic tag_t pc_tag(input logic [ADDR-1:0] pc);
        return pc[2+IDX_BITS +: TAG_BITS];
    endfunction

    logic [BTB_SETS-1:0][1:0] valid_q;
    logic [BTB_SETS-1:0]      lru_q;
    tag_t                     tag_q [BTB_SETS][2];
    logic [ADDR-1:0]          tgt_q [BTB_SETS][2];

    idx_t       u_idx, i_idx;
    tag_t       u_tag, i_tag;
    logic [1:0] i_match, u_match, v_eff;
    logic       i_way, i_apply, same_entry, lru_eff, u_way;

    always_comb begin
        u_idx      = pc_idx(upd_pc);
        u_tag      = pc_tag(upd_pc);
        i_idx      = pc_idx(inval_pc);
        i_tag      = pc_tag(inval_pc);
        i_match[0] = valid_q[i_idx][0] && (tag_q[i_idx][0] == i_tag);
        i_match[1] = valid_q[i_idx][1] && (tag_q[i_idx][1] == i_tag);
        i_way      = !i_match[0];
        same_entry = upd_valid && (u_idx == i_idx) && (u_tag == i_tag);
        i_apply    = inval_valid && (|i_match) && !same_entry;
        // The update sees the set as it looks after a same-set invalidate
        v_eff      = valid_q[u_idx];
        lru_eff    = lru_q[u_idx];
        if (i_apply && (i_idx == u_idx)) begin
            v_eff[i_way] = 1'b0;
            lru_eff      = i_way;
        end
        u_match[0] = v_eff[0] && (tag_q[u_idx][0] == u_tag);
        u_match[1] = v_eff[1] && (tag_q[u_idx][1] == u_tag);
        if (u_match[0])      u_way = 1'b0;
        else if (u_match[1]) u_way = 1'b1;
        else if (!v_eff[0])  u_way = 1'b0;
        else if (!v_eff[1])  u_way = 1'b1;
        else                 u_way = lru_eff;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            lru_q   <= '0;
        end else begin
            if (i_apply) begin
                valid_q[i_idx][i_way] <= 1'b0;
                lru_q[i_idx]          <= i_way;
            end
            if (upd_valid) begin
                valid_q[u_idx][u_way] <= 1'b1;
                lru_q[u_idx]          <= ~u_way;
            end
        end
    end

    // Payload is qualified by valid bits, so it needs no reset
    always_ff @(posedge clock) begin
        if (upd_valid) begin
            tag_q[u_idx][u_way] <= u_tag;
            tgt_q[u_idx][u_way] <= upd_target;
        end
    end

    always_comb begin
        btb_hits    = '0;
        btb_targets = '0;
        for (int i = 0; i < N; i++) begin
            idx_t            l_idx;
            tag_t            l_tag;
            logic            m0, m1, hit;
            logic [ADDR-1:0] tgt;
            l_idx = pc_idx(PCs_in[i]);
            l_tag = pc_tag(PCs_in[i]);
            m0    = valid_q[l_idx][0] && (tag_q[l_idx][0] == l_tag);
            m1    = valid_q[l_idx][1] && (tag_q[l_idx][1] == l_tag);
            hit   = m0 || m1;
            tgt   = m0 ? tgt_q[l_idx][0] : tgt_q[l_idx][1];
`ifdef BTB_BYPASS_EN
            if (upd_valid && (u_idx == l_idx) && (u_tag == l_tag)) begin
                hit = 1'b1;
                tgt = upd_target;
            end else if (inval_valid && (i_idx == l_idx) && (i_tag == l_tag)) begin
                hit = 1'b0;
            end
`endif
            btb_hits[i]    = reset && slots_valid[i] && hit;
            btb_targets[i] = btb_hits[i] ? tgt : '0;
        end
    end

    // j-th hit in slot order lands on grant row j
    always_comb begin
        int cnt;
        branch_gnt_bus = '0;
        cnt            = 0;
        for (int i = 0; i < N; i++) begin
            if (btb_hits[i]) begin
                branch_gnt_bus[cnt][i] = 1'b1;
                cnt++;
            end
        end
    end

    assign no_branches_fetched = ~|btb_hits;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: directed vectors, expected values queued.
module tb_branch_target_buffer;

    localparam int N = 3;

    logic               clock = 1'b0;
    logic               reset;
    logic [N-1:0][31:0] PCs_in;
    logic [N-1:0]       slots_valid;
    logic [N-1:0]       btb_hits;
    logic [N-1:0][31:0] btb_targets;
    logic [N-1:0][N-1:0] branch_gnt_bus;
    logic               no_branches_fetched;
    logic               upd_valid;
    logic [31:0]        upd_pc, upd_target;
    logic               inval_valid;
    logic [31:0]        inval_pc;

    branch_target_buffer #(.N(N)) dut (
        .clock               (clock),
        .reset               (reset),
        .PCs_in              (PCs_in),
        .slots_valid         (slots_valid),
        .btb_hits            (btb_hits),
        .btb_targets         (btb_targets),
        .branch_gnt_bus      (branch_gnt_bus),
        .no_branches_fetched (no_branches_fetched),
        .upd_valid           (upd_valid),
        .upd_pc              (upd_pc),
        .upd_target          (upd_target),
        .inval_valid         (inval_valid),
        .inval_pc            (inval_pc)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [N-1:0]        hits;
        logic [N-1:0][31:0]  tg;
        logic [N-1:0][N-1:0] gnt;
        logic                nb;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    vectors = 0;
    int    miscompares = 0;

    task automatic chk(input string nm, input logic [2:0] h,
                       input logic [31:0] t0, t1, t2,
                       input logic [2:0] g0, g1, g2);
        exp_t e;
        e.hits = h;
        e.tg   = {t2, t1, t0};
        e.gnt  = {g2, g1, g0};
        e.nb   = (h == 3'b000);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic drv(input logic [31:0] p0, p1, p2, input logic [2:0] sv,
                       input logic uv, input logic [31:0] up, ut,
                       input logic iv, input logic [31:0] ip);
        @(posedge clock);
        #1;
        PCs_in      = {p2, p1, p0};
        slots_valid = sv;
        upd_valid   = uv;
        upd_pc      = up;
        upd_target  = ut;
        inval_valid = iv;
        inval_pc    = ip;
    endtask

    task automatic look(input logic [31:0] p0, p1, p2);
        drv(p0, p1, p2, 3'b111, 1'b0, 0, 0, 1'b0, 0);
    endtask

    task automatic upd(input logic [31:0] up, ut);
        drv(32'h104, 32'h108, 32'h10C, 3'b111, 1'b1, up, ut, 1'b0, 0);
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                exp_t  e;
                string nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                vectors++;
                if (btb_hits !== e.hits || btb_targets !== e.tg ||
                    branch_gnt_bus !== e.gnt ||
                    no_branches_fetched !== e.nb) begin
                    miscompares++;
                    $display("FAIL %s: got hits=%b tgt=%h gnt=%h nb=%b, want hits=%b tgt=%h gnt=%h nb=%b",
                             nm, btb_hits, btb_targets, branch_gnt_bus,
                             no_branches_fetched, e.hits, e.tg, e.gnt, e.nb);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset       = 1'b0;
        PCs_in      = '0;
        slots_valid = '0;
        upd_valid   = 1'b0;
        upd_pc      = '0;
        upd_target  = '0;
        inval_valid = 1'b0;
        inval_pc    = '0;

        look(32'h100, 32'h104, 32'h108);
        chk("rst_hold", 3'b000, 0, 0, 0, 0, 0, 0);
        look(32'h100, 32'h104, 32'h108);
        reset = 1'b1;
        chk("empty", 3'b000, 0, 0, 0, 0, 0, 0);

        drv(32'h100, 32'h104, 32'h108, 3'b111, 1'b1, 32'h104, 32'h200, 1'b0, 0);
`ifdef BTB_BYPASS_EN
        chk("train_cycle", 3'b010, 0, 32'h200, 0, 3'b010, 0, 0);
`else
        chk("train_cycle", 3'b000, 0, 0, 0, 0, 0, 0);
`endif
        look(32'h100, 32'h104, 32'h108);
        chk("hit104", 3'b010, 0, 32'h200, 0, 3'b010, 0, 0);

        upd(32'h100, 32'hA00);
        upd(32'h500, 32'hB00);
        upd(32'h900, 32'hC00);
        look(32'h100, 32'h500, 32'h900);
        chk("evict", 3'b110, 0, 32'hB00, 32'hC00, 3'b010, 3'b100, 0);

        upd(32'h100, 32'h300);
        drv(32'h104, 32'h108, 32'h10C, 3'b111, 1'b1, 32'h100, 32'h400,
            1'b1, 32'h100);
        look(32'h100, 32'h104, 32'h900);
        chk("upd_wins", 3'b111, 32'h400, 32'h200, 32'hC00,
            3'b001, 3'b010, 3'b100);

        drv(32'h100, 32'h500, 32'h900, 3'b111, 1'b0, 0, 0, 1'b1, 32'h100);
`ifdef BTB_BYPASS_EN
        chk("inval_cycle", 3'b100, 0, 0, 32'hC00, 3'b100, 0, 0);
`else
        chk("inval_cycle", 3'b101, 32'h400, 0, 32'hC00, 3'b001, 3'b100, 0);
`endif
        look(32'h100, 32'h500, 32'h900);
        chk("inval", 3'b100, 0, 0, 32'hC00, 3'b100, 0, 0);

        upd(32'hD00, 32'hE00);
        look(32'h900, 32'hD00, 32'h100);
        chk("reuse", 3'b011, 32'hC00, 32'hE00, 0, 3'b001, 3'b010, 0);

        upd(32'h500, 32'hF00);
        look(32'h900, 32'hD00, 32'h500);
        chk("lru", 3'b110, 0, 32'hE00, 32'hF00, 3'b010, 3'b100, 0);

        drv(32'h104, 32'h108, 32'h10C, 3'b111, 1'b1, 32'h100, 32'h1100,
            1'b1, 32'h500);
        look(32'h100, 32'hD00, 32'h500);
        chk("freed_way", 3'b011, 32'h1100, 32'hE00, 0, 3'b001, 3'b010, 0);

        drv(32'h100, 32'h100, 32'h100, 3'b111, 1'b1, 32'h10C, 32'h1200,
            1'b1, 32'h104);
        look(32'h104, 32'h10C, 32'h108);
        chk("diff_sets", 3'b010, 0, 32'h1200, 0, 3'b010, 0, 0);

        drv(32'h100, 32'hD00, 32'h10C, 3'b101, 1'b0, 0, 0, 1'b0, 0);
        chk("slot_mask", 3'b101, 32'h1100, 0, 32'h1200, 3'b001, 3'b100, 0);

        drv(32'h100, 32'hD00, 32'h10C, 3'b111, 1'b1, 32'h108, 32'h1300,
            1'b0, 0);
        #2;
        reset = 1'b0;
        chk("rst_mid", 3'b000, 0, 0, 0, 0, 0, 0);
        drv(32'h100, 32'hD00, 32'h108, 3'b111, 1'b1, 32'h108, 32'h1300,
            1'b0, 0);
        chk("rst_low", 3'b000, 0, 0, 0, 0, 0, 0);
        look(32'h100, 32'h10C, 32'h108);
        reset = 1'b1;
        chk("post_rst", 3'b000, 0, 0, 0, 0, 0, 0);
        look(32'h100, 32'h10C, 32'h108);
        chk("dropped", 3'b000, 0, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clock);
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
